// File: rtl/sr_pulse_gen_pkg.sv
// Shared types and constants for the sr_pulse_gen set/reset command stage.
package sr_pulse_gen_pkg;

  localparam logic [1:0] ENC_LOW       = 2'b00;
  localparam logic [1:0] ENC_RISE_WAIT = 2'b01;
  localparam logic [1:0] ENC_HIGH      = 2'b11;
  localparam logic [1:0] ENC_FALL_WAIT = 2'b10;

  localparam int MIN_DEBOUNCE = 2;

  typedef enum logic [1:0] {
    LOW       = ENC_LOW,
    RISE_WAIT = ENC_RISE_WAIT,
    HIGH      = ENC_HIGH,
    FALL_WAIT = ENC_FALL_WAIT
  } deb_state_t;

endpackage

// File: rtl/sr_pulse_gen_if.sv
// Button inputs and s/r command outputs of sr_pulse_gen, grouped as one bundle.
interface sr_pulse_gen_if;
  logic set_btn;
  logic clr_btn;
  logic s;
  logic r;
  logic set_lvl;
  logic clr_lvl;
  logic conflict;

  modport master (
    output set_btn, clr_btn,
    input  s, r, set_lvl, clr_lvl, conflict
  );

  modport slave (
    input  set_btn, clr_btn,
    output s, r, set_lvl, clr_lvl, conflict
  );
endinterface

// File: rtl/sr_pulse_gen_debounce.sv
// One debounce channel: level FSM, sample counter and a one-cycle rising-edge flag.
//   state     | meaning
//   LOW       | debounced level 0, raw agrees
//   RISE_WAIT | raw is 1, counting samples before level goes 1
//   HIGH      | debounced level 1, raw agrees
//   FALL_WAIT | raw is 0, counting samples before level goes 0
module sr_debounce
  import sr_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  // Values below the minimum would let a single-sample glitch flip the level.
  localparam int DEB = (DEBOUNCE_CYCLES < MIN_DEBOUNCE) ? MIN_DEBOUNCE : DEBOUNCE_CYCLES;
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEB - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    case (state_q)
      LOW: begin
        if (raw_i) begin
          state_d = RISE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RISE_WAIT: begin
        if (!raw_i) begin
          state_d = LOW;
        end else if (cnt_q == CNT_TC) begin
          state_d = HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!raw_i) begin
          state_d = FALL_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      FALL_WAIT: begin
        if (raw_i) begin
          state_d = HIGH;
        end else if (cnt_q == CNT_TC) begin
          state_d = LOW;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = LOW;
    endcase
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/sr_pulse_gen.sv
// Debounced set/clear buttons to exclusive one-cycle s/r pulses for the ffsr flop.
// Define SR_PULSE_GEN_SYNC_EN to add 2-flop input synchronisers (+2 cycles latency).
module sr_pulse_gen
  import sr_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3,
  parameter int CLR_PRIO        = 1
) (
  input  logic           clk,
  input  logic           rstn,
  sr_pulse_gen_if.slave  bus
);

  localparam logic CLR_WINS = (CLR_PRIO != 0);

  logic set_raw, clr_raw;

`ifdef SR_PULSE_GEN_SYNC_EN
  logic [1:0] set_sync_q, clr_sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      set_sync_q <= 2'b00;
      clr_sync_q <= 2'b00;
    end else begin
      set_sync_q <= {set_sync_q[0], bus.set_btn};
      clr_sync_q <= {clr_sync_q[0], bus.clr_btn};
    end
  end

  assign set_raw = set_sync_q[1];
  assign clr_raw = clr_sync_q[1];
`else
  assign set_raw = bus.set_btn;
  assign clr_raw = bus.clr_btn;
`endif

  logic set_lvl, clr_lvl, set_rise, clr_rise;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_set (
    .clk     (clk),
    .rstn    (rstn),
    .raw_i   (set_raw),
    .level_o (set_lvl),
    .rise_o  (set_rise)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_clr (
    .clk     (clk),
    .rstn    (rstn),
    .raw_i   (clr_raw),
    .level_o (clr_lvl),
    .rise_o  (clr_rise)
  );

  logic s_q, s_d, r_q, r_d, conflict_q, conflict_d;

  // Loser of a simultaneous edge is dropped, never queued, so s and r stay exclusive.
  always_comb begin
    conflict_d = set_rise & clr_rise;
    s_d        = set_rise & ~(clr_rise & CLR_WINS);
    r_d        = clr_rise & ~(set_rise & ~CLR_WINS);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.conflict = conflict_q;
  assign bus.set_lvl  = set_lvl;
  assign bus.clr_lvl  = clr_lvl;

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Scoreboard bench for sr_pulse_gen: expected pulses queued at stimulus time, checked at output.
module tb_sr_pulse_gen;

  localparam int D = 4;
`ifdef SR_PULSE_GEN_SYNC_EN
  localparam int X = 2;
`else
  localparam int X = 0;
`endif
  localparam int L = D + X;

  typedef struct {
    int   cyc;
    logic s;
    logic r;
    logic c;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic q_ff;

  sr_pulse_gen_if bus ();
  sr_pulse_gen_if bus_p0 ();

  assign bus_p0.set_btn = bus.set_btn;
  assign bus_p0.clr_btn = bus.clr_btn;

  sr_pulse_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .CLR_PRIO(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  sr_pulse_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .CLR_PRIO(0)) dut_p0 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_p0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ffsr fed by the DUT command pulses.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) q_ff <= 1'b0;
    else if (bus.s === 1'b1) q_ff <= 1'b1;
    else if (bus.r === 1'b1) q_ff <= 1'b0;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.s === 1'b1 || bus.r === 1'b1 || bus.conflict === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: cyc=%0d s=%b r=%b conflict=%b, required no pulse",
                 cyc, bus.s, bus.r, bus.conflict);
      end else begin
        e = sb.pop_front();
        if (e.cyc !== cyc || bus.s !== e.s || bus.r !== e.r || bus.conflict !== e.c) begin
          bad++;
          $display("FAIL pulse: got cyc=%0d s=%b r=%b conflict=%b, required cyc=%0d s=%b r=%b conflict=%b",
                   cyc, bus.s, bus.r, bus.conflict, e.cyc, e.s, e.r, e.c);
        end
      end
    end
  end

  task automatic push(input int c, input logic s, input logic r, input logic cf);
    exp_t e;
    e.cyc = c; e.s = s; e.r = r; e.c = cf;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int lim;
    lim = cyc + 60;
    while (sb.size() != 0 && cyc < lim) @(negedge clk);
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_pulse: pending=%0d, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic release_all();
    bus.set_btn = 1'b0;
    bus.clr_btn = 1'b0;
    repeat (L + 4) @(negedge clk);
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b, required %b at cyc=%0d", name, act, req, cyc);
    end
  endtask

  task automatic test_reset();
    int m;
    #3 rstn = 1'b0;
    #1;
    check_bit("rst_s", bus.s, 1'b0);
    check_bit("rst_r", bus.r, 1'b0);
    check_bit("rst_set_lvl", bus.set_lvl, 1'b0);
    check_bit("rst_clr_lvl", bus.clr_lvl, 1'b0);
    check_bit("rst_conflict", bus.conflict, 1'b0);
    bus.clr_btn = 1'b0;
    repeat (2) @(negedge clk);
    m = cyc;
    rstn = 1'b1;
    push(m + 1 + L, 1'b1, 1'b0, 1'b0);
    wait_cyc(m + L - 1);
    check_bit("rst_lvl_before", bus.set_lvl, 1'b0);
    @(negedge clk);
    check_bit("rst_lvl_after", bus.set_lvl, 1'b1);
    drain("reset");
    release_all();
  endtask

  task automatic test_bounce();
    int m;
    m = cyc;
    bus.set_btn = 1'b1;
    repeat (3) @(negedge clk);
    bus.set_btn = 1'b0;
    @(negedge clk);
    bus.set_btn = 1'b1;
    push(m + 5 + L, 1'b1, 1'b0, 1'b0);
    wait_cyc(m + 3 + L);
    check_bit("bounce_lvl_low", bus.set_lvl, 1'b0);
    wait_cyc(m + 4 + L);
    check_bit("bounce_lvl_high", bus.set_lvl, 1'b1);
    drain("bounce");
    release_all();
    check_bit("bounce_lvl_released", bus.set_lvl, 1'b0);
  endtask

  task automatic test_same_cycle();
    int m;
    m = cyc;
    bus.set_btn = 1'b1;
    bus.clr_btn = 1'b1;
    push(m + 1 + L, 1'b0, 1'b1, 1'b1);
    wait_cyc(m + L);
    check_bit("p0_s_early", bus_p0.s, 1'b0);
    @(negedge clk);
    check_bit("p0_s", bus_p0.s, 1'b1);
    check_bit("p0_r", bus_p0.r, 1'b0);
    check_bit("p0_conflict", bus_p0.conflict, 1'b1);
    @(negedge clk);
    check_bit("p0_s_one_cycle", bus_p0.s, 1'b0);
    check_bit("p0_conflict_one_cycle", bus_p0.conflict, 1'b0);
    drain("same_cycle");
    release_all();
  endtask

  task automatic test_staggered();
    int m;
    m = cyc;
    bus.set_btn = 1'b1;
    push(m + 1 + L, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus.clr_btn = 1'b1;
    push(m + 2 + L, 1'b0, 1'b1, 1'b0);
    wait_cyc(m + 2 + L);
    check_bit("ffsr_q_set", q_ff, 1'b1);
    @(negedge clk);
    check_bit("ffsr_q_clear", q_ff, 1'b0);
    check_bit("stag_set_lvl", bus.set_lvl, 1'b1);
    check_bit("stag_clr_lvl", bus.clr_lvl, 1'b1);
    drain("staggered");
    release_all();
  endtask

  task automatic test_hold_release();
    int m;
    m = cyc;
    bus.set_btn = 1'b1;
    push(m + 1 + L, 1'b1, 1'b0, 1'b0);
    wait_cyc(m + 20);
    bus.set_btn = 1'b0;
    wait_cyc(m + 19 + L);
    check_bit("hold_lvl_still_high", bus.set_lvl, 1'b1);
    @(negedge clk);
    check_bit("hold_lvl_fell", bus.set_lvl, 1'b0);
    wait_cyc(m + 30);
    bus.set_btn = 1'b1;
    push(m + 31 + L, 1'b1, 1'b0, 1'b0);
    drain("hold_release");
    release_all();
  endtask

  task automatic test_reset_mid();
    int m, m2;
    m = cyc;
    bus.set_btn = 1'b1;
    wait_cyc(m + 2 + X);
    rstn = 1'b0;
    #1;
    check_bit("mid_rst_lvl", bus.set_lvl, 1'b0);
    check_bit("mid_rst_s", bus.s, 1'b0);
    repeat (3) @(negedge clk);
    m2 = cyc;
    rstn = 1'b1;
    push(m2 + 1 + L, 1'b1, 1'b0, 1'b0);
    drain("reset_mid");
    check_bit("mid_lvl_after", bus.set_lvl, 1'b1);
    release_all();
  endtask

  initial begin
    rstn = 1'b1;
    bus.set_btn = 1'b1;
    bus.clr_btn = 1'b1;
    test_reset();
    test_bounce();
    test_same_cycle();
    test_staggered();
    test_hold_release();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
